// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard/sequencing controller.
// The datapath side (master) drives the observed pipeline state; the controller (slave) drives the controls.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      instr_id;
  logic             idex_mem_rd;
  logic [4:0]       idex_rt;
  logic             branch_taken;
  logic             imem_ready;
  logic             dmem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_hold;
  logic             timeout_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output instr_id, idex_mem_rd, idex_rt, branch_taken, imem_ready, dmem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, timeout_err,
    input  state, stall_cnt, flush_cnt
  );

  modport slave (
    input  instr_id, idex_mem_rd, idex_rt, branch_taken, imem_ready, dmem_busy,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, timeout_err,
    output state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the IF/ID register and PC: load-use stalls,
// branch flushes, fetch bubbles, data-memory freeze with timeout recovery, saturating statistics.
module pipeline_hazard_ctrl #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hif
);

  localparam int WC_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_RECOVER  = 2'd3
  } state_t;

  state_t           state_q,     state_d;
  logic [WC_W-1:0]  wait_cnt_q,  wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             timeout_q,   timeout_d;

  logic pc_write_s;
  logic ifid_write_s;
  logic ifid_flush_s;
  logic idex_bubble_s;
  logic pipe_hold_s;
  logic lu_haz_s;

  // Opcodes whose rt field is a source operand (R-type, beq, bne, sw).
  function automatic logic uses_rt_f(input logic [5:0] op);
    logic r;
    case (op)
      6'h00, 6'h04, 6'h05, 6'h2B: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

  // Load-use hazard between the ID/EX load and the IF/ID instruction
  always_comb begin
    lu_haz_s = 1'b0;
    if (hif.idex_mem_rd && (hif.idex_rt != 5'd0)) begin
      lu_haz_s = (hif.idex_rt == hif.instr_id[25:21]) ||
                 (uses_rt_f(hif.instr_id[31:26]) && (hif.idex_rt == hif.instr_id[20:16]));
    end else begin
      lu_haz_s = 1'b0;
    end
  end

  // Next-state and Mealy control outputs
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_d     = timeout_q;
    pc_write_s    = 1'b1;
    ifid_write_s  = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_bubble_s = 1'b0;
    pipe_hold_s   = 1'b0;
    case (state_q)
      ST_RUN, ST_LU_STALL: begin
        // LU_STALL skips the hazard check: ID/EX already holds the inserted bubble
        if (hif.dmem_busy) begin
          pc_write_s   = 1'b0;
          ifid_write_s = 1'b0;
          pipe_hold_s  = 1'b1;
          state_d      = ST_MEM_WAIT;
          wait_cnt_d   = WC_W'(1);
        end else if (hif.branch_taken) begin
          ifid_flush_s  = 1'b1;
          idex_bubble_s = 1'b1;
          state_d       = ST_RUN;
        end else if (lu_haz_s && (state_q == ST_RUN)) begin
          pc_write_s    = 1'b0;
          ifid_write_s  = 1'b0;
          idex_bubble_s = 1'b1;
          state_d       = ST_LU_STALL;
        end else if (!hif.imem_ready) begin
          pc_write_s   = 1'b0;
          ifid_flush_s = 1'b1;
          state_d      = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        pc_write_s   = 1'b0;
        ifid_write_s = 1'b0;
        pipe_hold_s  = 1'b1;
        if (!hif.dmem_busy) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q < WC_W'(WAIT_MAX)) begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end else begin
          state_d   = ST_RECOVER;
          timeout_d = 1'b1;
        end
      end
      ST_RECOVER: begin
        pc_write_s    = 1'b0;
        ifid_flush_s  = 1'b1;
        idex_bubble_s = 1'b1;
        state_d       = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Saturating statistics
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (ifid_flush_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State, wait counter, statistics and sticky timeout registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= {WC_W{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // While reset is held the pipeline is frozen regardless of the FSM decode
  assign hif.pc_write    = reset & pc_write_s;
  assign hif.ifid_write  = reset & ifid_write_s;
  assign hif.ifid_flush  = reset & ifid_flush_s;
  assign hif.idex_bubble = reset & idex_bubble_s;
  assign hif.pipe_hold   = ~reset | pipe_hold_s;
  assign hif.timeout_err = timeout_q;
  assign hif.state       = state_q;
  assign hif.stall_cnt   = stall_cnt_q;
  assign hif.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; control vector is {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W    = 5;
  localparam int WAIT_MAX = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

  pipeline_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .hif   (hif)
  );

  always #5 clock = ~clock;

  function automatic logic [4:0] ctl();
    return {hif.pc_write, hif.ifid_write, hif.ifid_flush, hif.idex_bubble, hif.pipe_hold};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    hif.instr_id     = 32'h0000_0000;
    hif.idex_mem_rd  = 1'b0;
    hif.idex_rt      = 5'd0;
    hif.branch_taken = 1'b0;
    hif.imem_ready   = 1'b1;
    hif.dmem_busy    = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    hif.dmem_busy = 1'b1;
    #3;
    checks++; if (ctl() !== 5'b00001) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), 5'b00001); end
    checks++; if (hif.state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", hif.state); end
    checks++; if (hif.stall_cnt !== 5'd0 || hif.flush_cnt !== 5'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", hif.stall_cnt, hif.flush_cnt); end
    checks++; if (hif.timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", hif.timeout_err); end
    tick();
    tick();
    checks++; if (hif.state !== 2'd0 || hif.stall_cnt !== 5'd0) begin failures++; $display("FAIL reset_held state=%0d stall=%0d exp=0/0", hif.state, hif.stall_cnt); end
    set_idle();
    reset = 1'b1;
  endtask

  task automatic test_run();
    for (int i = 0; i < 5; i++) begin
      #2;
      checks++; if (ctl() !== 5'b11000) begin failures++; $display("FAIL run_ctl cyc=%0d got=%b exp=%b", i, ctl(), 5'b11000); end
      tick();
    end
    checks++; if (hif.state !== 2'd0 || hif.stall_cnt !== 5'd0 || hif.flush_cnt !== 5'd0) begin
      failures++; $display("FAIL run_regs state=%0d stall=%0d flush=%0d exp=0/0/0", hif.state, hif.stall_cnt, hif.flush_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    hif.idex_mem_rd = 1'b1;
    hif.idex_rt     = 5'd5;
    hif.instr_id    = 32'h00A5_3020;
    #2;
    checks++; if (ctl() !== 5'b00010) begin failures++; $display("FAIL lu_ctl got=%b exp=%b", ctl(), 5'b00010); end
    tick();
    #2;
    checks++; if (hif.state !== 2'd1) begin failures++; $display("FAIL lu_state got=%0d exp=1", hif.state); end
    checks++; if (ctl() !== 5'b11000) begin failures++; $display("FAIL lu_release_ctl got=%b exp=%b", ctl(), 5'b11000); end
    tick();
    set_idle();
    checks++; if (hif.state !== 2'd0 || hif.stall_cnt !== 5'd1) begin failures++; $display("FAIL lu_after state=%0d stall=%0d exp=0/1", hif.state, hif.stall_cnt); end
  endtask

  task automatic test_uses_rt();
    logic [31:0] instrs [4] = '{32'h8CA6_0000, 32'h8C25_0000, 32'hAC25_0000, 32'h0000_0000};
    logic [4:0]  rts    [4] = '{5'd5, 5'd5, 5'd5, 5'd0};
    logic [4:0]  exps   [4] = '{5'b00010, 5'b11000, 5'b00010, 5'b11000};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      hif.idex_mem_rd = 1'b1;
      hif.idex_rt     = rts[i];
      hif.instr_id    = instrs[i];
      #2;
      checks++; if (ctl() !== exps[i]) begin failures++; $display("FAIL uses_rt instr=%h got=%b exp=%b", instrs[i], ctl(), exps[i]); end
    end
    set_idle();
  endtask

  task automatic test_branch_over_hazard();
    do_reset();
    hif.idex_mem_rd  = 1'b1;
    hif.idex_rt      = 5'd5;
    hif.instr_id     = 32'h00A5_3020;
    hif.branch_taken = 1'b1;
    #2;
    checks++; if (ctl() !== 5'b11110) begin failures++; $display("FAIL br_ctl got=%b exp=%b", ctl(), 5'b11110); end
    tick();
    set_idle();
    checks++; if (hif.state !== 2'd0 || hif.flush_cnt !== 5'd1 || hif.stall_cnt !== 5'd0) begin
      failures++; $display("FAIL br_after state=%0d flush=%0d stall=%0d exp=0/1/0", hif.state, hif.flush_cnt, hif.stall_cnt);
    end
  endtask

  task automatic test_imem_bubble();
    do_reset();
    hif.imem_ready = 1'b0;
    #2;
    checks++; if (ctl() !== 5'b01100) begin failures++; $display("FAIL imem_ctl got=%b exp=%b", ctl(), 5'b01100); end
    tick();
    set_idle();
    checks++; if (hif.state !== 2'd0 || hif.stall_cnt !== 5'd1 || hif.flush_cnt !== 5'd1) begin
      failures++; $display("FAIL imem_after state=%0d stall=%0d flush=%0d exp=0/1/1", hif.state, hif.stall_cnt, hif.flush_cnt);
    end
  endtask

  task automatic test_mem_wait_short();
    do_reset();
    hif.dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (ctl() !== 5'b00001) begin failures++; $display("FAIL mw_ctl cyc=%0d got=%b exp=%b", i, ctl(), 5'b00001); end
      tick();
      checks++; if (hif.state !== 2'd2) begin failures++; $display("FAIL mw_state cyc=%0d got=%0d exp=2", i, hif.state); end
    end
    hif.dmem_busy = 1'b0;
    #2;
    checks++; if (ctl() !== 5'b00001) begin failures++; $display("FAIL mw_exit_ctl got=%b exp=%b", ctl(), 5'b00001); end
    tick();
    #2;
    checks++; if (hif.state !== 2'd0 || ctl() !== 5'b11000) begin failures++; $display("FAIL mw_back state=%0d ctl=%b exp=0/11000", hif.state, ctl()); end
    checks++; if (hif.timeout_err !== 1'b0 || hif.stall_cnt !== 5'd4) begin
      failures++; $display("FAIL mw_regs timeout=%b stall=%0d exp=0/4", hif.timeout_err, hif.stall_cnt);
    end
  endtask

  task automatic test_timeout();
    logic [4:0] exp_ctl;
    logic [1:0] exp_state;
    do_reset();
    hif.dmem_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_ctl = (i == 17) ? 5'b01110 : 5'b00001;
      #2;
      checks++; if (ctl() !== exp_ctl) begin failures++; $display("FAIL to_ctl cyc=%0d got=%b exp=%b", i, ctl(), exp_ctl); end
      tick();
      exp_state = (i <= 15) ? 2'd2 : (i == 16) ? 2'd3 : (i == 17) ? 2'd0 : 2'd2;
      checks++; if (hif.state !== exp_state || hif.timeout_err !== (i >= 16)) begin
        failures++; $display("FAIL to_state cyc=%0d state=%0d timeout=%b exp=%0d/%b", i, hif.state, hif.timeout_err, exp_state, (i >= 16));
      end
    end
    hif.dmem_busy = 1'b0;
    tick();
    checks++; if (hif.state !== 2'd0 || hif.stall_cnt !== 5'd21 || hif.flush_cnt !== 5'd1 || hif.timeout_err !== 1'b1) begin
      failures++; $display("FAIL to_after state=%0d stall=%0d flush=%0d timeout=%b exp=0/21/1/1", hif.state, hif.stall_cnt, hif.flush_cnt, hif.timeout_err);
    end
    do_reset();
    checks++; if (hif.timeout_err !== 1'b0) begin failures++; $display("FAIL to_cleared got=%b exp=0", hif.timeout_err); end
  endtask

  task automatic test_saturation();
    do_reset();
    hif.imem_ready = 1'b0;
    repeat (40) tick();
    checks++; if (hif.stall_cnt !== 5'd31 || hif.flush_cnt !== 5'd31) begin
      failures++; $display("FAIL sat_cnt stall=%0d flush=%0d exp=31/31", hif.stall_cnt, hif.flush_cnt);
    end
    hif.imem_ready = 1'b1;
    tick();
    checks++; if (hif.stall_cnt !== 5'd31) begin failures++; $display("FAIL sat_hold got=%0d exp=31", hif.stall_cnt); end
  endtask

  task automatic test_reset_abort();
    do_reset();
    hif.dmem_busy = 1'b1;
    tick();
    tick();
    checks++; if (hif.state !== 2'd2) begin failures++; $display("FAIL abort_pre got=%0d exp=2", hif.state); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (hif.state !== 2'd0 || ctl() !== 5'b00001 || hif.stall_cnt !== 5'd0) begin
      failures++; $display("FAIL abort state=%0d ctl=%b stall=%0d exp=0/00001/0", hif.state, ctl(), hif.stall_cnt);
    end
    set_idle();
    tick();
    reset = 1'b1;
    #2;
    checks++; if (ctl() !== 5'b11000) begin failures++; $display("FAIL abort_resume got=%b exp=%b", ctl(), 5'b11000); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_load_use();
    test_uses_rt();
    test_branch_over_hazard();
    test_imem_bubble();
    test_mem_wait_short();
    test_timeout();
    test_saturation();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
